// File: rtl/edge_detect.sv
// edge_detect: single-bit edge detector built as a small Moore FSM.
//
// The input x passes through an optional synchronizer chain. The detector
// compares each sample with the previous one and emits a one-clock pulse
// on y when the transition matches EDGE_MODE.
//
// Parameters:
//   EDGE_MODE   - 0 = rising, 1 = falling, 2 = both
//   SYNC_STAGES - 0..3 flops in front of the detector (0 = use x directly)
//   RESET_LEVEL - value taken as the previous sample at reset
//
// Ports:
//   clk   - rising-edge clock
//   rst_n - synchronous active-low reset
//   x     - level input to be monitored
//   y     - registered one-cycle edge pulse
//   level - registered copy of the last sample
//
// state   | meaning
// --------+---------------------------------------------
// IDLE_LO | last sample 0, no pulse
// IDLE_HI | last sample 1, no pulse
// PULSE_F | last sample 0, falling edge reported on y
// PULSE_R | last sample 1, rising edge reported on y

module edge_detect #(
  parameter int EDGE_MODE   = 0,
  parameter int SYNC_STAGES = 0,
  parameter int RESET_LEVEL = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic x,
  output logic y,
  output logic level
);

  generate
    if (EDGE_MODE < 0 || EDGE_MODE > 2 || SYNC_STAGES < 0 || SYNC_STAGES > 3 ||
        RESET_LEVEL < 0 || RESET_LEVEL > 1) begin : g_bad_param
      $error("edge_detect: illegal parameter value");
    end
  endgenerate

  localparam logic RISE_EN = (EDGE_MODE == 0) || (EDGE_MODE == 2);
  localparam logic FALL_EN = (EDGE_MODE == 1) || (EDGE_MODE == 2);
  localparam logic RST_BIT = (RESET_LEVEL != 0);

  // Encoding puts y in bit 1 and level in bit 0 so both outputs come
  // straight off the state flops.
  typedef enum logic [1:0] {
    IDLE_LO = 2'b00,
    IDLE_HI = 2'b01,
    PULSE_F = 2'b10,
    PULSE_R = 2'b11
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   s;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign s = x;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync_q;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          sync_q <= {SYNC_STAGES{RST_BIT}};
        end else begin
          sync_q[0] <= x;
          for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
          end
        end
      end

      assign s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= RST_BIT ? IDLE_HI : IDLE_LO;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE_LO: if (s)  state_nxt = RISE_EN ? PULSE_R : IDLE_HI;
      IDLE_HI: if (!s) state_nxt = FALL_EN ? PULSE_F : IDLE_LO;
      PULSE_R: state_nxt = s ? IDLE_HI : (FALL_EN ? PULSE_F : IDLE_LO);
      PULSE_F: state_nxt = s ? (RISE_EN ? PULSE_R : IDLE_HI) : IDLE_LO;
      default: state_nxt = IDLE_LO;
    endcase
  end

  assign y     = state[1];
  assign level = state[0];

endmodule

// File: tb/tb_edge_detect.sv
// Testbench for edge_detect. Five instances share clk, rst_n and x:
//   A: rising,  no sync,  reset level 0
//   B: falling, no sync,  reset level 0
//   C: both,    no sync,  reset level 0
//   D: both,    2 stages, reset level 0
//   E: rising,  1 stage,  reset level 1
// Each table row is applied before one posedge; its expected y/level
// (bit order A B C D E, A in bit 4) is pushed into a scoreboard queue and a
// separate monitor compares just after that posedge.

module tb_edge_detect;

  logic clk = 1'b0;
  logic rst_n;
  logic x;
  logic [4:0] y_v;
  logic [4:0] l_v;

  always #5 clk = ~clk;

  edge_detect #(.EDGE_MODE(0), .SYNC_STAGES(0), .RESET_LEVEL(0)) u_a (
    .clk(clk), .rst_n(rst_n), .x(x), .y(y_v[4]), .level(l_v[4]));
  edge_detect #(.EDGE_MODE(1), .SYNC_STAGES(0), .RESET_LEVEL(0)) u_b (
    .clk(clk), .rst_n(rst_n), .x(x), .y(y_v[3]), .level(l_v[3]));
  edge_detect #(.EDGE_MODE(2), .SYNC_STAGES(0), .RESET_LEVEL(0)) u_c (
    .clk(clk), .rst_n(rst_n), .x(x), .y(y_v[2]), .level(l_v[2]));
  edge_detect #(.EDGE_MODE(2), .SYNC_STAGES(2), .RESET_LEVEL(0)) u_d (
    .clk(clk), .rst_n(rst_n), .x(x), .y(y_v[1]), .level(l_v[1]));
  edge_detect #(.EDGE_MODE(0), .SYNC_STAGES(1), .RESET_LEVEL(1)) u_e (
    .clk(clk), .rst_n(rst_n), .x(x), .y(y_v[0]), .level(l_v[0]));

  // r = rst_n, x = level held over the edge, g = glitch x between edges
  typedef struct packed {
    logic       r;
    logic       x;
    logic       g;
    logic [4:0] y;
    logic [4:0] l;
  } vec_t;

  typedef struct packed {
    int         idx;
    logic [4:0] y;
    logic [4:0] l;
  } exp_t;

  localparam int NVEC = 20;

  vec_t vecs [NVEC] = '{
    {1'b0, 1'b0, 1'b0, 5'b00000, 5'b00001},  // 0  reset, x=0
    {1'b1, 1'b1, 1'b0, 5'b10100, 5'b11101},  // 1  first rise
    {1'b1, 1'b1, 1'b1, 5'b00000, 5'b11101},  // 2  low glitch between edges
    {1'b1, 1'b1, 1'b0, 5'b00010, 5'b11111},  // 3  held high
    {1'b1, 1'b0, 1'b0, 5'b01100, 5'b00011},  // 4  fall
    {1'b1, 1'b1, 1'b0, 5'b10100, 5'b11110},  // 5  short high pulse
    {1'b1, 1'b0, 1'b0, 5'b01111, 5'b00001},  // 6
    {1'b1, 1'b0, 1'b0, 5'b00010, 5'b00010},  // 7
    {1'b1, 1'b1, 1'b0, 5'b10110, 5'b11100},  // 8  toggle every cycle
    {1'b1, 1'b0, 1'b0, 5'b01101, 5'b00001},  // 9
    {1'b1, 1'b1, 1'b0, 5'b10110, 5'b11110},  // 10
    {1'b1, 1'b0, 1'b0, 5'b01111, 5'b00001},  // 11
    {1'b1, 1'b0, 1'b0, 5'b00010, 5'b00010},  // 12
    {1'b1, 1'b0, 1'b0, 5'b00010, 5'b00000},  // 13
    {1'b1, 1'b1, 1'b0, 5'b10100, 5'b11100},  // 14 rise, y high after
    {1'b0, 1'b1, 1'b0, 5'b00000, 5'b00001},  // 15 reset mid-pulse
    {1'b1, 1'b1, 1'b0, 5'b10100, 5'b11101},  // 16 release with x=1
    {1'b1, 1'b1, 1'b0, 5'b00000, 5'b11101},  // 17
    {1'b1, 1'b1, 1'b0, 5'b00010, 5'b11111},  // 18
    {1'b1, 1'b1, 1'b0, 5'b00000, 5'b11111}   // 19
  };

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;
  int   popped = 0;

  // Monitor: every row produces an output sample just after its posedge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        popped++;
        total++;
        if (y_v !== e.y) begin
          bad++;
          $display("FAIL y row %0d: got %b want %b (ABCDE)", e.idx, y_v, e.y);
        end
        total++;
        if (l_v !== e.l) begin
          bad++;
          $display("FAIL level row %0d: got %b want %b (ABCDE)", e.idx, l_v, e.l);
        end
      end
    end
  end

  initial begin
    exp_t e;
    for (int k = 0; k < NVEC; k++) begin
      if (k > 0) @(negedge clk);
      rst_n = vecs[k].r;
      x     = vecs[k].x;
      e.idx = k;
      e.y   = vecs[k].y;
      e.l   = vecs[k].l;
      sb_q.push_back(e);
      if (vecs[k].g) begin
        #1 x = ~vecs[k].x;
        #2 x = vecs[k].x;
      end
    end

    for (int i = 0; i < 50 && sb_q.size() != 0; i++) @(posedge clk);
    #3;
    total++;
    if (sb_q.size() != 0 || popped != NVEC) begin
      bad++;
      $display("FAIL drain: checked %0d rows, want %0d", popped, NVEC);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
